// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues pipelined ROM reads and
// buffers returned words in a prefetch FIFO that decode drains via valid/ready.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 24,
  parameter int                INSTR_W  = 24,
  parameter int                DEPTH    = 4,
  parameter int                ROM_LAT  = 1,
  parameter int                PC_STEP  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pcload_i,
  input  logic [ADDR_W-1:0]  pcload_addr_i,
  output logic               rom_req_o,
  output logic [ADDR_W-1:0]  rom_addr_o,
  input  logic [INSTR_W-1:0] rom_instr_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 3;

  logic [ADDR_W-1:0]  r_fetchPc;
  logic [ROM_LAT-1:0] r_pipeValid;
  logic [ADDR_W-1:0]  r_pipePc [ROM_LAT];
  logic [INSTR_W-1:0] r_fifoInstr [DEPTH];
  logic [ADDR_W-1:0]  r_fifoPc [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;

  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_req;
  logic [SUM_W-1:0]   w_inflight;
  logic [SUM_W-1:0]   w_used;
  logic [SUM_W-1:0]   w_limit;
  logic [ROM_LAT-1:0] w_pipeValidNext;
  logic [CNT_W-1:0]   w_countNext;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      w_inflight = w_inflight + SUM_W'(r_pipeValid[i]);
    end
  end

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && instr_ready_i;
  assign w_push  = r_pipeValid[ROM_LAT-1];

  // A slot is claimed at request time, so buffered plus in-flight words never exceed DEPTH.
  assign w_used  = SUM_W'(r_count) + w_inflight;
  assign w_limit = SUM_W'(DEPTH) + SUM_W'(w_pop);
  assign w_req   = rst_ni && !pcload_i && (w_used < w_limit);

  assign w_pipeValidNext = ROM_LAT'({r_pipeValid, w_req});
  assign w_countNext     = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fetchPc   <= RESET_PC;
      r_pipeValid <= '0;
      r_count     <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
    end else if (pcload_i) begin
      r_fetchPc   <= pcload_addr_i;
      r_pipeValid <= '0;
      r_count     <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
    end else begin
      if (w_req) begin
        r_fetchPc <= r_fetchPc + ADDR_W'(PC_STEP);
      end
      r_pipeValid <= w_pipeValidNext;
      r_count     <= w_countNext;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
    end
  end

  // Data-only storage; its contents only matter where the valid bits say so.
  always_ff @(posedge clk_i) begin
    r_pipePc[0] <= r_fetchPc;
    for (int i = 1; i < ROM_LAT; i++) begin
      r_pipePc[i] <= r_pipePc[i-1];
    end
    if (w_push && rst_ni && !pcload_i) begin
      r_fifoInstr[r_wrPtr] <= rom_instr_i;
      r_fifoPc[r_wrPtr]    <= r_pipePc[ROM_LAT-1];
    end
  end

  assign rom_req_o     = w_req;
  assign rom_addr_o    = w_req ? r_fetchPc : '0;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_fifoInstr[r_rdPtr] : '0;
  assign instr_pc_o    = w_valid ? r_fifoPc[r_rdPtr] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: one instance with ROM_LAT=1 and one with
// ROM_LAT=3, each fed by a ROM model returning ~address after the ROM latency.
module tb_instr_fetch_unit;

  localparam int AW    = 24;
  localparam int IW    = 24;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstA_n, pcloadA, readyA, romReqA, validA;
  logic [AW-1:0] pcloadAddrA, romAddrA, instrPcA;
  logic [IW-1:0] romInstrA, instrA;
  logic          rstB_n, pcloadB, readyB, romReqB, validB;
  logic [AW-1:0] pcloadAddrB, romAddrB, instrPcB;
  logic [IW-1:0] romInstrB, instrB;

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .ROM_LAT(1),
                     .PC_STEP(2), .RESET_PC(24'h0)) dutA (
    .clk_i(clk), .rst_ni(rstA_n), .pcload_i(pcloadA), .pcload_addr_i(pcloadAddrA),
    .rom_req_o(romReqA), .rom_addr_o(romAddrA), .rom_instr_i(romInstrA),
    .instr_valid_o(validA), .instr_ready_i(readyA), .instr_o(instrA), .instr_pc_o(instrPcA)
  );

  instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .ROM_LAT(3),
                     .PC_STEP(2), .RESET_PC(24'h0)) dutB (
    .clk_i(clk), .rst_ni(rstB_n), .pcload_i(pcloadB), .pcload_addr_i(pcloadAddrB),
    .rom_req_o(romReqB), .rom_addr_o(romAddrB), .rom_instr_i(romInstrB),
    .instr_valid_o(validB), .instr_ready_i(readyB), .instr_o(instrB), .instr_pc_o(instrPcB)
  );

  // ROM models: the word for address a is ~a, presented ROM_LAT cycles after the request.
  logic [AW-1:0] romPipeA = '0;
  logic [AW-1:0] romPipeB [3] = '{default: '0};
  always @(posedge clk) begin
    romPipeA    <= romAddrA;
    romPipeB[0] <= romAddrB;
    romPipeB[1] <= romPipeB[0];
    romPipeB[2] <= romPipeB[1];
  end
  assign romInstrA = ~romPipeA;
  assign romInstrB = ~romPipeB[2];

  int checks = 0;
  int passes = 0;
  int cycleCnt = 0;
  logic [AW-1:0] expA[$];
  logic [AW-1:0] expB[$];
  int delCycA[$];
  int delCycB[$];
  int deliveredA = 0, deliveredB = 0;
  int reqCountA = 0;
  int outA = 0, outB = 0, maxOutA = 0, maxOutB = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  // Monitors: every accepted handshake pops the scoreboard; outstanding words tracked per DUT.
  always @(negedge clk) begin
    logic          popA;
    logic [AW-1:0] expPc;
    logic [IW-1:0] expInstr;
    popA = rstA_n && validA && readyA;
    if (rstA_n && romReqA) reqCountA++;
    if (popA) begin
      deliveredA++;
      delCycA.push_back(cycleCnt);
      checkOutput("A scoreboardHasEntry", 32'(expA.size() != 0), 1);
      if (expA.size() != 0) begin
        expPc    = expA.pop_front();
        expInstr = ~expPc;
        checkOutput("A instrPc", instrPcA, expPc);
        checkOutput("A instr", instrA, expInstr);
      end
    end
    outA = outA + (romReqA ? 1 : 0) - (popA ? 1 : 0);
    if (!rstA_n || pcloadA) outA = 0;
    if (outA > maxOutA) maxOutA = outA;
  end

  always @(negedge clk) begin
    logic          popB;
    logic [AW-1:0] expPc;
    logic [IW-1:0] expInstr;
    popB = rstB_n && validB && readyB;
    if (popB) begin
      deliveredB++;
      delCycB.push_back(cycleCnt);
      checkOutput("B scoreboardHasEntry", 32'(expB.size() != 0), 1);
      if (expB.size() != 0) begin
        expPc    = expB.pop_front();
        expInstr = ~expPc;
        checkOutput("B instrPc", instrPcB, expPc);
        checkOutput("B instr", instrB, expInstr);
      end
    end
    outB = outB + (romReqB ? 1 : 0) - (popB ? 1 : 0);
    if (!rstB_n || pcloadB) outB = 0;
    if (outB > maxOutB) maxOutB = outB;
  end

  task automatic applyStimulus(input bit useB, input logic rstN, input logic pcload,
                               input logic [AW-1:0] addr, input logic ready);
    if (useB) begin
      rstB_n = rstN; pcloadB = pcload; pcloadAddrB = addr; readyB = ready;
    end else begin
      rstA_n = rstN; pcloadA = pcload; pcloadAddrA = addr; readyA = ready;
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDelivered(input bit useB, input int target, input int budget, input string name);
    int n = 0;
    while ((useB ? deliveredB : deliveredA) < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, useB ? deliveredB : deliveredA, target);
  endtask

  task automatic checkNoBubble(input bit useB, input int startIdx, input int n, input string name);
    int span;
    span = -1;
    if (useB && delCycB.size() >= startIdx + n) span = delCycB[startIdx+n-1] - delCycB[startIdx];
    if (!useB && delCycA.size() >= startIdx + n) span = delCycA[startIdx+n-1] - delCycA[startIdx];
    checkOutput(name, span, n - 1);
  endtask

  task automatic checkAllZeroA(input string tag);
    checkOutput({tag, " romReq"}, romReqA, 0);
    checkOutput({tag, " romAddr"}, romAddrA, 0);
    checkOutput({tag, " valid"}, validA, 0);
    checkOutput({tag, " instr"}, instrA, 0);
    checkOutput({tag, " instrPc"}, instrPcA, 0);
  endtask

  task automatic checkAllZeroB(input string tag);
    checkOutput({tag, " romReq"}, romReqB, 0);
    checkOutput({tag, " romAddr"}, romAddrB, 0);
    checkOutput({tag, " valid"}, validB, 0);
    checkOutput({tag, " instr"}, instrB, 0);
    checkOutput({tag, " instrPc"}, instrPcB, 0);
  endtask

  initial begin
    int base;
    int idx;
    int n;
    applyStimulus(0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, '0, 1'b0);

    // Reset release with decode always ready: sequential fetch from 0.
    stepCycles(3);
    @(negedge clk);
    checkAllZeroA("A inReset");
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) expA.push_back(AW'(2 * i));
    idx = delCycA.size();
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("A firstReq", romReqA, 1);
    checkOutput("A firstAddr", romAddrA, 24'h0);
    checkOutput("A validCycle0", validA, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("A validCycle1", validA, 0);
    checkOutput("A secondAddr", romAddrA, 24'h2);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("A validCycle2", validA, 1);
    @(posedge clk); #1;
    waitDelivered(0, 8, 40, "A t1 delivered");
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b0);
    checkNoBubble(0, idx, 8, "A t1 noBubble");

    // Decode stalled after reset: credits stop issue at DEPTH words.
    applyStimulus(0, 1'b0, 1'b0, '0, 1'b0);
    stepCycles(2);
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b0);
    base = reqCountA;
    stepCycles(8);
    checkOutput("A t2 requests", reqCountA - base, 4);
    checkOutput("A t2 reqIdle", romReqA, 0);
    checkOutput("A t2 headValid", validA, 1);
    checkOutput("A t2 headPc", instrPcA, 24'h0);
    for (int i = 0; i < 6; i++) expA.push_back(AW'(2 * i));
    idx = delCycA.size();
    base = deliveredA;
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b1);
    waitDelivered(0, base + 6, 40, "A t2 delivered");
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b0);
    checkNoBubble(0, idx, 6, "A t2 noBubble");

    // Redirect with two words buffered and one in flight.
    applyStimulus(0, 1'b1, 1'b1, 24'h10, 1'b0);
    stepCycles(1);
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b0);
    stepCycles(3);
    checkOutput("A t3 bufferedHead", instrPcA, 24'h10);
    for (int i = 0; i < 4; i++) expA.push_back(AW'(24'h100 + 2 * i));
    base = deliveredA;
    applyStimulus(0, 1'b1, 1'b1, 24'h100, 1'b0);
    stepCycles(1);
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("A t3 gap1", validA, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("A t3 gap2", validA, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("A t3 resume", validA, 1);
    @(posedge clk); #1;
    waitDelivered(0, base + 4, 40, "A t3 delivered");
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b0);

    // Fetch PC wraps past the top of the address space.
    expA.push_back(24'hFFFFFE);
    expA.push_back(24'h000000);
    expA.push_back(24'h000002);
    base = deliveredA;
    applyStimulus(0, 1'b1, 1'b1, 24'hFFFFFE, 1'b0);
    stepCycles(1);
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b1);
    waitDelivered(0, base + 3, 40, "A t4 delivered");
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b0);

    // Redirect in the same cycle that pc 0x20 is accepted.
    for (int i = 0; i < 5; i++) expA.push_back(AW'(24'h18 + 2 * i));
    expA.push_back(24'h300);
    expA.push_back(24'h302);
    base = deliveredA;
    applyStimulus(0, 1'b1, 1'b1, 24'h18, 1'b0);
    stepCycles(1);
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b1);
    n = 0;
    while (!(validA && instrPcA == 24'h20) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("A t5 headAt20", instrPcA, 24'h20);
    applyStimulus(0, 1'b1, 1'b1, 24'h300, 1'b1);
    stepCycles(1);
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b1);
    waitDelivered(0, base + 7, 40, "A t5 delivered");
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b0);

    // ROM_LAT=3 instance: sustained throughput, then reset while full.
    for (int i = 0; i < 12; i++) expB.push_back(AW'(2 * i));
    idx = delCycB.size();
    applyStimulus(1, 1'b1, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("B firstReq", romReqB, 1);
    checkOutput("B firstAddr", romAddrB, 24'h0);
    stepCycles(3);
    @(negedge clk);
    checkOutput("B validCycle3", validB, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("B validCycle4", validB, 1);
    @(posedge clk); #1;
    waitDelivered(1, 12, 60, "B t6 delivered");
    applyStimulus(1, 1'b1, 1'b0, '0, 1'b0);
    checkNoBubble(1, idx, 12, "B t6 noBubble");
    stepCycles(8);
    checkOutput("B fullHeadValid", validB, 1);
    checkOutput("B fullHeadPc", instrPcB, 24'h18);
    applyStimulus(1, 1'b0, 1'b0, '0, 1'b0);
    stepCycles(1);
    @(negedge clk);
    checkAllZeroB("B inReset");
    for (int i = 0; i < 3; i++) expB.push_back(AW'(2 * i));
    base = deliveredB;
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 1'b0, '0, 1'b1);
    waitDelivered(1, base + 3, 40, "B restart delivered");
    applyStimulus(1, 1'b1, 1'b0, '0, 1'b0);
    stepCycles(4);

    checkOutput("A scoreboardDrained", expA.size(), 0);
    checkOutput("B scoreboardDrained", expB.size(), 0);
    checkOutput("A maxOutstanding", maxOutA, DEPTH);
    checkOutput("B maxOutstanding", maxOutB, DEPTH);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
